// File: rtl/instr_fetch_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_seq_if
//  Description : Bundle for the Y86-64 fetch unit. Carries the fetch request
//                from the PC logic, the byte-wide instruction memory
//                handshake, and the decoded instruction fields returned to
//                the decode and PC-update stages.
//  Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_seq_if;
  // Fetch request from the PC register
  logic        start;
  logic [63:0] PCaddress;

  // Byte-wide instruction memory port
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        mem_err;

  // Fetch status and decoded fields
  logic        busy;
  logic        done;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic [63:0] valC;
  logic [63:0] valP;
  logic [2:0]  stat;

  // Fetch unit side
  modport master (
    input  start, PCaddress, mem_ack, mem_rdata, mem_err,
    output mem_req, mem_addr, busy, done,
    output icode, ifun, rA, rB, valC, valP, stat
  );

  // Environment side: PC logic plus instruction memory
  modport slave (
    output start, PCaddress, mem_ack, mem_rdata, mem_err,
    input  mem_req, mem_addr, busy, done,
    input  icode, ifun, rA, rB, valC, valP, stat
  );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_seq.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_seq
//  Description : Multi-cycle Y86-64 instruction fetch. Reads one instruction
//                a byte per memory handshake starting at PCaddress, sizes it
//                from icode, and returns icode/ifun/rA/rB/valC/valP/stat.
//                Memory faults and handshake timeouts abort with ADR, illegal
//                encodings abort with INS after the first byte.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_seq #(
  parameter int TIMEOUT = 16  // cycles without mem_ack before ADR abort (1..255)
) (
  input  logic              clk,
  input  logic              rst,
  instr_fetch_seq_if.master bus
);

  localparam logic [2:0] STAT_AOK  = 3'd1;
  localparam logic [2:0] STAT_HLT  = 3'd2;
  localparam logic [2:0] STAT_ADR  = 3'd3;
  localparam logic [2:0] STAT_INS  = 3'd4;
  localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [63:0] pc_q;        // latched PCaddress of this instruction
  logic [3:0]  n_q;         // index of the byte currently being requested
  logic [3:0]  len_q;       // instruction length, valid once byte 0 is in
  logic [7:0]  wait_q;      // cycles spent waiting on the current byte
  logic        mem_req_q;
  logic [63:0] mem_addr_q;
  logic        busy_q;
  logic        done_q;
  logic [3:0]  icode_q;
  logic [3:0]  ifun_q;
  logic [3:0]  ra_q;
  logic [3:0]  rb_q;
  logic [63:0] valc_q;
  logic [63:0] valp_q;
  logic [2:0]  stat_q;

  logic [7:0]  wait_d;
  logic [3:0]  dec_len;
  logic        dec_valid;
  logic [2:0]  valc_idx;
  logic [63:0] abort_valp;
  logic        fin;
  logic        adv;
  logic [2:0]  fin_stat;
  logic [63:0] fin_valp;

  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.icode    = icode_q;
  assign bus.ifun     = ifun_q;
  assign bus.rA       = ra_q;
  assign bus.rB       = rb_q;
  assign bus.valC     = valc_q;
  assign bus.valP     = valp_q;
  assign bus.stat     = stat_q;

  // Length and legality of an instruction whose first byte is on mem_rdata
  always_comb begin
    dec_len   = 4'd1;
    dec_valid = 1'b0;
    case (bus.mem_rdata[7:4])
      4'h0, 4'h1, 4'h9: begin dec_len = 4'd1;  dec_valid = (bus.mem_rdata[3:0] == 4'd0); end
      4'h2:             begin dec_len = 4'd2;  dec_valid = (bus.mem_rdata[3:0] <= 4'd6); end
      4'h6:             begin dec_len = 4'd2;  dec_valid = (bus.mem_rdata[3:0] <= 4'd3); end
      4'hA, 4'hB:       begin dec_len = 4'd2;  dec_valid = (bus.mem_rdata[3:0] == 4'd0); end
      4'h7:             begin dec_len = 4'd9;  dec_valid = (bus.mem_rdata[3:0] <= 4'd6); end
      4'h8:             begin dec_len = 4'd9;  dec_valid = (bus.mem_rdata[3:0] == 4'd0); end
      4'h3, 4'h4, 4'h5: begin dec_len = 4'd10; dec_valid = (bus.mem_rdata[3:0] == 4'd0); end
      default:          begin dec_len = 4'd1;  dec_valid = 1'b0; end
    endcase
  end

  // Decide whether this REQ cycle finishes the fetch, and with what status
  always_comb begin
    wait_d     = wait_q + 8'd1;
    // Aborted fetches report PC + bytes consumed, never less than one byte
    abort_valp = pc_q + ((n_q == 4'd0) ? 64'd1 : {60'd0, n_q});
    // valC starts at byte 1 for 9-byte forms and at byte 2 for 10-byte forms
    valc_idx   = (len_q == 4'd9) ? 3'(n_q - 4'd1) : 3'(n_q - 4'd2);
    fin        = 1'b0;
    adv        = 1'b0;
    fin_stat   = STAT_AOK;
    fin_valp   = pc_q + {60'd0, len_q};
    if (state_q == S_REQ) begin
      if (bus.mem_ack) begin
        if (bus.mem_err) begin
          fin      = 1'b1;
          fin_stat = STAT_ADR;
          fin_valp = abort_valp;
        end else if (n_q == 4'd0) begin
          if (!dec_valid) begin
            fin      = 1'b1;
            fin_stat = STAT_INS;
            fin_valp = pc_q + 64'd1;
          end else if (dec_len == 4'd1) begin
            fin      = 1'b1;
            fin_stat = (bus.mem_rdata[7:4] == 4'h0) ? STAT_HLT : STAT_AOK;
            fin_valp = pc_q + 64'd1;
          end else begin
            adv = 1'b1;
          end
        end else if (n_q == len_q - 4'd1) begin
          fin = 1'b1;
        end else begin
          adv = 1'b1;
        end
      end else if (wait_d == TIMEOUT_W) begin
        fin      = 1'b1;
        fin_stat = STAT_ADR;
        fin_valp = abort_valp;
      end
    end
  end

  // Fetch state machine with all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= 64'd0;
      n_q        <= 4'd0;
      len_q      <= 4'd1;
      wait_q     <= 8'd0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 64'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      icode_q    <= 4'h0;
      ifun_q     <= 4'h0;
      ra_q       <= 4'hF;
      rb_q       <= 4'hF;
      valc_q     <= 64'd0;
      valp_q     <= 64'd0;
      stat_q     <= STAT_AOK;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state_q    <= S_REQ;
            pc_q       <= bus.PCaddress;
            n_q        <= 4'd0;
            len_q      <= 4'd1;
            wait_q     <= 8'd0;
            mem_req_q  <= 1'b1;
            mem_addr_q <= bus.PCaddress;
            busy_q     <= 1'b1;
            icode_q    <= 4'h0;
            ifun_q     <= 4'h0;
            ra_q       <= 4'hF;
            rb_q       <= 4'hF;
            valc_q     <= 64'd0;
            valp_q     <= 64'd0;
            stat_q     <= STAT_AOK;
          end
        end
        S_REQ: begin
          // A faulting byte carries no data, so nothing is captured from it
          if (bus.mem_ack && !bus.mem_err) begin
            if (n_q == 4'd0) begin
              icode_q <= bus.mem_rdata[7:4];
              ifun_q  <= bus.mem_rdata[3:0];
              len_q   <= dec_len;
            end else if (n_q == 4'd1 && (len_q == 4'd2 || len_q == 4'd10)) begin
              ra_q <= bus.mem_rdata[7:4];
              rb_q <= bus.mem_rdata[3:0];
            end else begin
              valc_q[{valc_idx, 3'b000} +: 8] <= bus.mem_rdata;
            end
          end
          wait_q <= bus.mem_ack ? 8'd0 : wait_d;
          if (adv) begin
            n_q        <= n_q + 4'd1;
            mem_addr_q <= mem_addr_q + 64'd1;
          end
          if (fin) begin
            state_q   <= S_DONE;
            mem_req_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            stat_q    <= fin_stat;
            valp_q    <= fin_valp;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_seq
//  Description : Self-checking bench for instr_fetch_seq. Directed table of
//                fetches with hand-derived results, reset-in-flight sequence,
//                and randomized fetches checked against a byte-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_seq;

  localparam int TIMEOUT = 16;

  typedef struct packed {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
    logic [2:0]  stat;
    int          nreads;
    int          done_cyc;
  } exp_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [79:0] b;         // byte i at [8*i +: 8]
    int          wt;        // idle cycles before each ack
    int          err_at;    // byte index acked with mem_err, -1 none
    int          stall_at;  // byte index never acked, -1 none
    exp_t        e;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  instr_fetch_seq_if bus ();

  instr_fetch_seq #(.TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [79:0] by10(input logic [7:0] b0, b1, b2, b3, b4,
                                       input logic [7:0] b5, b6, b7, b8, b9);
    return {b9, b8, b7, b6, b5, b4, b3, b2, b1, b0};
  endfunction

  function automatic exp_t mke(input logic [3:0] ic, ifn, ra, rb,
                               input logic [63:0] valc, valp,
                               input logic [2:0] stat, input int nr, dc);
    exp_t e;
    e.icode = ic; e.ifun = ifn; e.ra = ra; e.rb = rb;
    e.valc = valc; e.valp = valp; e.stat = stat;
    e.nreads = nr; e.done_cyc = dc;
    return e;
  endfunction

  function automatic vec_t mkv(input logic [63:0] pc, input logic [79:0] b,
                               input int wt, err_at, stall_at, input exp_t e);
    vec_t v;
    v.pc = pc; v.b = b; v.wt = wt; v.err_at = err_at; v.stall_at = stall_at; v.e = e;
    return v;
  endfunction

  // Instruction-set rules: length by icode, legal ifun ranges
  function automatic int len_of(input logic [3:0] ic);
    case (ic)
      4'h2, 4'h6, 4'hA, 4'hB: return 2;
      4'h7, 4'h8:             return 9;
      4'h3, 4'h4, 4'h5:       return 10;
      default:                return 1;
    endcase
  endfunction

  function automatic bit legal(input logic [3:0] ic, input logic [3:0] fn);
    if (ic > 4'hB) return 0;
    if (ic == 4'h2 || ic == 4'h7) return fn <= 6;
    if (ic == 4'h6) return fn <= 3;
    return fn == 0;
  endfunction

  // Walk the byte stream as the instruction set describes it
  function automatic exp_t model(input logic [63:0] pc, input logic [79:0] b,
                                 input int wt, err_at, stall_at);
    exp_t e;
    int   len;
    int   cyc;
    logic [7:0] by;
    e = mke(4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0, 3'd1, 0, 0);
    len = 1;
    cyc = 1;
    for (int i = 0; i < 10; i++) begin
      if (i >= len) break;
      if (i == stall_at) begin
        e.stat = 3; e.valp = pc + 64'((i == 0) ? 1 : i);
        e.nreads = i; e.done_cyc = cyc + TIMEOUT;
        return e;
      end
      cyc += wt + 1;
      by = b[8*i +: 8];
      if (i == err_at) begin
        e.stat = 3; e.valp = pc + 64'((i == 0) ? 1 : i);
        e.nreads = i + 1; e.done_cyc = cyc;
        return e;
      end
      if (i == 0) begin
        e.icode = by[7:4];
        e.ifun  = by[3:0];
        len     = len_of(e.icode);
        if (!legal(e.icode, e.ifun)) begin
          e.stat = 4; e.valp = pc + 64'd1; e.nreads = 1; e.done_cyc = cyc;
          return e;
        end
        if (e.icode == 4'h0) e.stat = 2;
      end else if (i == 1 && (len == 2 || len == 10)) begin
        e.ra = by[7:4];
        e.rb = by[3:0];
      end else begin
        e.valc = e.valc | (64'(by) << (8 * (i - ((len == 9) ? 1 : 2))));
      end
    end
    e.valp = pc + 64'(len);
    e.nreads = len;
    e.done_cyc = cyc;
    return e;
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, ".mem_req"},  bus.mem_req,  64'd0);
    chk({tag, ".busy"},     bus.busy,     64'd0);
    chk({tag, ".done"},     bus.done,     64'd0);
    chk({tag, ".mem_addr"}, bus.mem_addr, 64'd0);
    chk({tag, ".icode"},    bus.icode,    64'h0);
    chk({tag, ".ifun"},     bus.ifun,     64'h0);
    chk({tag, ".rA"},       bus.rA,       64'hF);
    chk({tag, ".rB"},       bus.rB,       64'hF);
    chk({tag, ".valC"},     bus.valC,     64'd0);
    chk({tag, ".valP"},     bus.valP,     64'd0);
    chk({tag, ".stat"},     bus.stat,     64'd1);
  endtask

  // One fetch: start, act as memory cycle by cycle, then compare results
  task automatic run_check(input string tag, input logic [63:0] pc, input logic [79:0] b,
                           input int wt, err_at, stall_at, input bit spam, input exp_t e);
    int cyc;
    int idx;
    int w;
    bit got;
    bit proto_ok;
    @(negedge clk);
    bus.start = 1'b1; bus.PCaddress = pc; bus.mem_ack = 1'b0; bus.mem_err = 1'b0;
    cyc = 0; idx = 0; w = 0; got = 0; proto_ok = 1;
    while (!got && cyc < 200) begin
      @(negedge clk);
      cyc++;
      bus.start     = spam ? 1'($urandom) : 1'b0;
      bus.PCaddress = spam ? {$urandom, $urandom} : pc;
      bus.mem_ack   = 1'b0;
      bus.mem_err   = 1'b0;
      bus.mem_rdata = 8'($urandom);
      if (bus.done) begin
        got = 1;
        bus.mem_ack = 1'($urandom);   // stray ack while no request is open
        bus.mem_err = 1'($urandom);
      end else begin
        if (!bus.busy || !bus.mem_req) proto_ok = 0;
        if (bus.mem_addr !== pc + 64'(idx)) proto_ok = 0;
        if (idx != stall_at && idx < 10) begin
          if (w < wt) w++;
          else begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = b[8*idx +: 8];
            bus.mem_err   = (idx == err_at);
            idx++;
            w = 0;
          end
        end
      end
    end
    chk({tag, ".done_seen"}, 64'(got), 64'd1);
    if (got) begin
      chk({tag, ".done_cycle"}, 64'(cyc), 64'(e.done_cyc));
      chk({tag, ".reads"},      64'(idx), 64'(e.nreads));
      chk({tag, ".addr_req"},   64'(proto_ok), 64'd1);
      chk({tag, ".icode"},      bus.icode, 64'(e.icode));
      chk({tag, ".ifun"},       bus.ifun,  64'(e.ifun));
      chk({tag, ".rA"},         bus.rA,    64'(e.ra));
      chk({tag, ".rB"},         bus.rB,    64'(e.rb));
      chk({tag, ".valC"},       bus.valC,  e.valc);
      chk({tag, ".valP"},       bus.valP,  e.valp);
      chk({tag, ".stat"},       bus.stat,  64'(e.stat));
    end
    @(negedge clk);
    chk({tag, ".after_done"}, {61'd0, bus.done, bus.busy, bus.mem_req}, 64'd0);
    chk({tag, ".hold_valP"},  bus.valP, e.valp);
    bus.start = 1'b0; bus.mem_ack = 1'b0; bus.mem_err = 1'b0;
  endtask

  initial begin
    vec_t        tv[15];
    logic [63:0] pc;
    logic [79:0] b;
    int          wt, err_at, stall_at;
    exp_t        e;

    tv[0]  = mkv(64'h100, by10(8'h30, 8'hF3, 8'h08, 0, 0, 0, 0, 0, 0, 0), 0, -1, -1,
                 mke(4'h3, 4'h0, 4'hF, 4'h3, 64'h8, 64'h10A, 3'd1, 10, 11));
    tv[1]  = mkv(64'h40, by10(8'h73, 8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11, 0),
                 2, -1, -1,
                 mke(4'h7, 4'h3, 4'hF, 4'hF, 64'h1122334455667788, 64'h49, 3'd1, 9, 28));
    tv[2]  = mkv(64'h0, by10(8'h90, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, -1, -1,
                 mke(4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 64'h1, 3'd1, 1, 2));
    tv[3]  = mkv(64'h0, by10(8'h00, 8'h55, 0, 0, 0, 0, 0, 0, 0, 0), 0, -1, -1,
                 mke(4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h1, 3'd2, 1, 2));
    tv[4]  = mkv(64'h0, by10(8'hC0, 8'h12, 0, 0, 0, 0, 0, 0, 0, 0), 0, -1, -1,
                 mke(4'hC, 4'h0, 4'hF, 4'hF, 64'h0, 64'h1, 3'd4, 1, 2));
    tv[5]  = mkv(64'h0, by10(8'h27, 8'h12, 0, 0, 0, 0, 0, 0, 0, 0), 0, -1, -1,
                 mke(4'h2, 4'h7, 4'hF, 4'hF, 64'h0, 64'h1, 3'd4, 1, 2));
    tv[6]  = mkv(64'h200, by10(8'h30, 8'hF4, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88),
                 0, 5, -1,
                 mke(4'h3, 4'h0, 4'hF, 4'h4, 64'h332211, 64'h205, 3'd3, 6, 7));
    tv[7]  = mkv(64'h300, by10(8'h20, 8'h12, 0, 0, 0, 0, 0, 0, 0, 0), 0, -1, 1,
                 mke(4'h2, 4'h0, 4'hF, 4'hF, 64'h0, 64'h301, 3'd3, 1, 18));
    tv[8]  = mkv(64'h500, by10(8'h61, 8'hAB, 0, 0, 0, 0, 0, 0, 0, 0), 0, -1, -1,
                 mke(4'h6, 4'h1, 4'hA, 4'hB, 64'h0, 64'h502, 3'd1, 2, 3));
    tv[9]  = mkv(64'h600, by10(8'h64, 8'hAB, 0, 0, 0, 0, 0, 0, 0, 0), 0, -1, -1,
                 mke(4'h6, 4'h4, 4'hF, 4'hF, 64'h0, 64'h601, 3'd4, 1, 2));
    tv[10] = mkv(64'hFFFF_FFFF_FFFF_FFFE,
                 by10(8'h80, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 0), 1, -1, -1,
                 mke(4'h8, 4'h0, 4'hF, 4'hF, 64'h0807060504030201, 64'h7, 3'd1, 9, 19));
    tv[11] = mkv(64'h800, by10(8'h30, 8'hF1, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, -1,
                 mke(4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h801, 3'd3, 1, 2));
    tv[12] = mkv(64'h900, by10(8'h11, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, -1, -1,
                 mke(4'h1, 4'h1, 4'hF, 4'hF, 64'h0, 64'h901, 3'd4, 1, 2));
    tv[13] = mkv(64'hA00, by10(8'h40, 8'h5A, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08),
                 1, -1, 4,
                 mke(4'h4, 4'h0, 4'h5, 4'hA, 64'h0201, 64'hA04, 3'd3, 4, 25));
    tv[14] = mkv(64'hB00, by10(8'hB0, 8'hF7, 0, 0, 0, 0, 0, 0, 0, 0), 3, -1, -1,
                 mke(4'hB, 4'h0, 4'hF, 4'h7, 64'h0, 64'hB02, 3'd1, 2, 9));

    rst = 1'b1;
    bus.start = 1'b0; bus.PCaddress = 64'd0;
    bus.mem_ack = 1'b0; bus.mem_rdata = 8'd0; bus.mem_err = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 15; i++) begin
      run_check($sformatf("vec%0d", i), tv[i].pc, tv[i].b, tv[i].wt, tv[i].err_at,
                tv[i].stall_at, (i % 4) == 1, tv[i].e);
    end

    // Reset in the middle of a movq fetch, with acks still arriving
    @(negedge clk);
    bus.start = 1'b1; bus.PCaddress = 64'hC00;
    @(negedge clk);
    bus.start = 1'b0; bus.mem_ack = 1'b1; bus.mem_rdata = 8'h30;
    @(negedge clk);
    bus.mem_rdata = 8'hF2;
    @(negedge clk);
    bus.mem_rdata = 8'h55;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.mem_rdata = 8'h66;   // late ack with no request open
    check_reset_vals("midrst");
    @(negedge clk);
    bus.mem_ack = 1'b0;
    check_reset_vals("midrst_stray");
    run_check("wrap_nop", 64'hFFFF_FFFF_FFFF_FFFF, by10(8'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0),
              0, -1, -1, 1'b0, mke(4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 3'd1, 1, 2));

    // Randomized fetches against the model
    for (int r = 0; r < 120; r++) begin
      pc = ($urandom_range(0, 4) == 0) ? (64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15)))
                                       : {$urandom, $urandom};
      for (int k = 0; k < 10; k++) b[8*k +: 8] = 8'($urandom);
      b[7:4] = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 11)) : 4'($urandom_range(0, 15));
      b[3:0] = ($urandom_range(0, 4) < 3) ? 4'h0 : 4'($urandom_range(0, 7));
      wt       = $urandom_range(0, 2);
      err_at   = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 9) : -1;
      stall_at = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 9) : -1;
      e = model(pc, b, wt, err_at, stall_at);
      run_check($sformatf("rnd%0d", r), pc, b, wt, err_at, stall_at, (r % 3) == 0, e);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
